// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM master: command codes,
// FSM state encoding and frame geometry.
package spi_ram_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_RECV  = 3'd4,
    ST_END   = 3'd5
  } state_t;

  function automatic logic [FRAME_BITS-1:0] frame_word(
    input logic [1:0]           c,
    input logic [DATA_BITS-1:0] d
  );
    return {c, d};
  endfunction

endpackage

// File: rtl/spi_ram_master_shifter.sv
// Loadable PISO transmit register and SIPO receive register
// shared by the SPI RAM master frame sequencer.
module spi_shifter
  import spi_ram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [FRAME_BITS-1:0] frame_i,
  input  logic                  tx_adv_i,
  input  logic                  rx_adv_i,
  input  logic                  sin_i,
  output logic                  sout_o,
  output logic [DATA_BITS-1:0]  rx_next_o
);

  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [DATA_BITS-1:0]  rx_q, rx_d;

  assign sout_o    = tx_q[FRAME_BITS-1];
  assign rx_next_o = {rx_q[DATA_BITS-2:0], sin_i};

  always_comb begin
    tx_d = tx_q;
    rx_d = rx_q;
    if (load_i) begin
      tx_d = frame_i;
    end else if (tx_adv_i) begin
      tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
    end
    if (rx_adv_i) begin
      rx_d = rx_next_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      tx_q <= tx_d;
      rx_q <= rx_d;
    end
  end

endmodule

// File: rtl/spi_ram_master.sv
// SPI RAM master frame sequencer: header, 10-bit frame, optional gap+receive.
// Optional frame counter output enabled by SPI_RAM_MASTER_FRMCNT_EN.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int unsigned READ_GAP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SS_n
`ifdef SPI_RAM_MASTER_FRMCNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [3:0] SHIFT_LAST = 4'(FRAME_BITS - 1);
  localparam logic [3:0] GAP_LAST   = 4'(READ_GAP - 1);
  localparam logic [3:0] RECV_LAST  = 4'(DATA_BITS - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] cmd_q, cmd_d;
  logic       ss_n_q, ss_n_d;
  logic       mosi_q, mosi_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       rv_q, rv_d;
  logic [7:0] rdata_q, rdata_d;

  logic       load;
  logic       tx_adv;
  logic       rx_adv;
  logic       sout;
  logic [7:0] rx_next;

  spi_shifter u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .frame_i   (frame_word(cmd, wdata)),
    .tx_adv_i  (tx_adv),
    .rx_adv_i  (rx_adv),
    .sin_i     (MISO),
    .sout_o    (sout),
    .rx_next_o (rx_next)
  );

  // Outputs are registered: every branch sets the values
  // that the pins will show in the state being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    ss_n_d  = 1'b1;
    mosi_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rv_d    = 1'b0;
    rdata_d = rdata_q;
    load    = 1'b0;
    tx_adv  = 1'b0;
    rx_adv  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          cmd_d   = cmd;
          load    = 1'b1;
          state_d = ST_HDR;
          ss_n_d  = 1'b0;
          mosi_d  = cmd[1];
          busy_d  = 1'b1;
        end
      end
      ST_HDR: begin
        state_d = ST_SHIFT;
        cnt_d   = SHIFT_LAST;
        ss_n_d  = 1'b0;
        mosi_d  = sout;
        tx_adv  = 1'b1;
      end
      ST_SHIFT: begin
        ss_n_d = 1'b0;
        if (cnt_q == 4'd0) begin
          if (cmd_q == CMD_RD_DATA) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LAST;
          end else begin
            state_d = ST_END;
            ss_n_d  = 1'b1;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q - 4'd1;
          mosi_d = sout;
          tx_adv = 1'b1;
        end
      end
      ST_GAP: begin
        ss_n_d = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = ST_RECV;
          cnt_d   = RECV_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RECV: begin
        ss_n_d = 1'b0;
        rx_adv = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = ST_END;
          ss_n_d  = 1'b1;
          done_d  = 1'b1;
          rv_d    = 1'b1;
          rdata_d = rx_next;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      cmd_q   <= 2'b00;
      ss_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      ss_n_q  <= ss_n_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
    end
  end

  assign SS_n        = ss_n_q;
  assign MOSI        = mosi_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rdata_valid = rv_q;
  assign rdata       = rdata_q;

`ifdef SPI_RAM_MASTER_FRMCNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (done_q) begin
      fcnt_d = fcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= 16'd0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  assign frame_cnt = fcnt_q;
`endif

endmodule

// File: doc/spi_ram_master.md
SPI_RAM_MASTER -- requirements
Module: spi_ram_master

Interface
REQ-001 Parameter: READ_GAP, default 2, meaning idle SCLK-free cycles between the last payload bit and the first MISO sample on a read-data frame (range 1..7).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request pulse; accepted only in IDLE.
REQ-005 cmd  input  2  frame type: 00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
REQ-006 wdata  input  8  payload byte (address or data; don't-care for 11).
REQ-007 busy  output  1  high from the cycle after acceptance until done.
REQ-008 done  output  1  one-cycle pulse at end of every frame.
REQ-009 rdata  output  8  byte received on a read-data frame.
REQ-010 rdata_valid  output  1  one-cycle pulse with done on read-data frames only.
REQ-011 MOSI  output  1  serial data to slave, MSB first.
REQ-012 MISO  input  1  serial data from slave, MSB first.
REQ-013 SS_n  output  1  active-low slave select.

Function
REQ-014 FSM states IDLE, HDR, SHIFT, GAP, RECV, END; encodings come from the shared package.
REQ-015 IDLE: start=1 latches cmd and wdata, moves to HDR next cycle; start in any other state is ignored, with no queueing.
REQ-016 HDR (1 cycle): SS_n=0, MOSI=cmd[1] (slave write/read selector).
REQ-017 SHIFT (10 cycles): SS_n=0, MOSI carries {cmd, wdata} MSB first; a 4-bit counter counts 9 down to 0.
REQ-018 After SHIFT: cmd=11 goes to GAP, otherwise to END.
REQ-019 GAP (READ_GAP cycles): SS_n=0, MOSI=0.
REQ-020 RECV (8 cycles): SS_n=0, MISO sampled each rising edge into an 8-bit shift register, MSB first.
REQ-021 END (1 cycle): SS_n=1, done=1; rdata is updated and rdata_valid=1 only if cmd=11; next state is IDLE.
REQ-022 Latency, acceptance at cycle T: write/addr frames drive SS_n low T+1..T+11 and pulse done at T+12; read-data frames pulse done at T+20+READ_GAP.
REQ-023 SS_n stays high for at least one cycle (END) between frames; a start in END is ignored.
REQ-024 rdata holds its value until the next read-data frame completes.
REQ-025 MOSI=0 whenever SS_n=1.

Reset
REQ-026 rst_n low forces asynchronously: state IDLE, SS_n=1, MOSI=0, busy=0, done=0, rdata_valid=0, rdata=8'h00, counters 0.
REQ-027 Reset mid-frame aborts the frame with no done pulse; a new start is accepted on the first edge after release.

Configuration
REQ-028 Macro SPI_RAM_MASTER_FRMCNT_EN adds output frame_cnt[15:0], which increments on every done and wraps 16'hFFFF to 0, with reset value 0.
REQ-029 Without the macro, the frame_cnt port and counter do not exist and all other behaviour is identical.

Structure
REQ-030 Shared package spi_ram_pkg holds the cmd encodings (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA), the FSM state typedef, and FRAME_BITS=10 and DATA_BITS=8.
REQ-031 One sub-module, spi_shifter: a loadable 10-bit parallel-in/serial-out and 8-bit serial-in/parallel-out shift register instantiated by the FSM.

Verification
REQ-032 cmd=00, wdata=8'h3C, start at T -> MOSI sequence 0,0,0,0,0,1,1,1,1,0,0 over T+1..T+11; done at T+12; no rdata_valid.
REQ-033 cmd=11, READ_GAP=2, MISO model returns 8'hA5 MSB-first from T+14 -> header bit 1 then payload 1,1,x..; rdata=8'hA5 and rdata_valid with done at T+22.
REQ-034 Loopback with the slave-plus-RAM wrapper: write-addr 8'h10, write-data 8'h5A, read-addr 8'h10, read-data -> rdata=8'h5A.
REQ-035 start pulsed during SHIFT and during END -> ignored; exactly one done per accepted start.
REQ-036 rst_n low at cycle T+5 of a write frame -> SS_n=1 immediately, no done; the next start produces a full, correct frame.
REQ-037 With SPI_RAM_MASTER_FRMCNT_EN, 65537 frames -> frame_cnt=1.
